// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer in front of the ALU.
// Holds decoded ops until both operands are available (captured from the
// ALU and LSB CDBs), then dispatches one ready entry per cycle through
// registered outputs. A mispredict flush drops every entry.
// Optional build macro RS_AGE_SELECT_EN: select the oldest ready entry
// (by wrapping issue sequence number) instead of the lowest-index one.
module reservation_station #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned RS_WIDTH = 4,
  parameter int unsigned TAG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [6:0]        issue_opcode,
  input  logic [31:0]       issue_pc,
  input  logic [31:0]       issue_imm,
  input  logic [31:0]       issue_vj,
  input  logic [31:0]       issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              issue_qj_busy,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_name,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_name,
  input  logic [31:0]       alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_name,
  input  logic [31:0]       lsb_cdb_value,
  output logic              rs_full,
  output logic              alu_en,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_rs1,
  output logic [31:0]       alu_rs2,
  output logic [31:0]       alu_imm,
  output logic [6:0]        alu_opcode,
  output logic [TAG_W-1:0]  alu_name
);

  // Per-entry state
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [6:0]         opcode_q [RS_SIZE];
  logic [6:0]         opcode_d [RS_SIZE];
  logic [31:0]        pc_q     [RS_SIZE];
  logic [31:0]        pc_d     [RS_SIZE];
  logic [31:0]        imm_q    [RS_SIZE];
  logic [31:0]        imm_d    [RS_SIZE];
  logic [31:0]        vj_q     [RS_SIZE];
  logic [31:0]        vj_d     [RS_SIZE];
  logic [31:0]        vk_q     [RS_SIZE];
  logic [31:0]        vk_d     [RS_SIZE];
  logic [TAG_W-1:0]   qj_q     [RS_SIZE];
  logic [TAG_W-1:0]   qj_d     [RS_SIZE];
  logic [TAG_W-1:0]   qk_q     [RS_SIZE];
  logic [TAG_W-1:0]   qk_d     [RS_SIZE];
  logic [TAG_W-1:0]   name_q   [RS_SIZE];
  logic [TAG_W-1:0]   name_d   [RS_SIZE];
`ifdef RS_AGE_SELECT_EN
  logic [RS_WIDTH:0]  seq_q    [RS_SIZE];
  logic [RS_WIDTH:0]  seq_d    [RS_SIZE];
  logic [RS_WIDTH:0]  seq_cnt_q, seq_cnt_d;
`endif

  // Registered dispatch outputs
  logic              alu_en_q, alu_en_d;
  logic [31:0]       alu_pc_q, alu_pc_d;
  logic [31:0]       alu_rs1_q, alu_rs1_d;
  logic [31:0]       alu_rs2_q, alu_rs2_d;
  logic [31:0]       alu_imm_q, alu_imm_d;
  logic [6:0]        alu_opcode_q, alu_opcode_d;
  logic [TAG_W-1:0]  alu_name_q, alu_name_d;

  logic [RS_SIZE-1:0]  ready;
  logic [RS_WIDTH-1:0] free_idx, sel_idx;
  logic                sel_found;
  logic                issue_j_bypass, issue_k_bypass;
  logic [31:0]         issue_j_value, issue_k_value;

  assign ready   = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign rs_full = &busy_q;

`ifdef RS_AGE_SELECT_EN
  // a is older than b when a-b wraps negative (in-flight span < half range)
  function automatic logic is_older(input logic [RS_WIDTH:0] a, input logic [RS_WIDTH:0] b);
    logic [RS_WIDTH:0] diff;
    diff = a - b;
    return diff[RS_WIDTH];
  endfunction
`endif

  // Lowest-index free slot for the incoming op
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = RS_WIDTH'(i);
    end
  end

  // Pick one ready entry to dispatch (oldest or lowest index)
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!sel_found || is_older(seq_q[i], seq_q[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
    end
`endif
  end

  // Issue-time bypass: grab an operand broadcast in the same cycle (ALU first)
  always_comb begin
    issue_j_bypass = 1'b0;
    issue_j_value  = issue_vj;
    if (issue_qj_busy && alu_cdb_valid && alu_cdb_name == issue_qj) begin
      issue_j_bypass = 1'b1;
      issue_j_value  = alu_cdb_value;
    end else if (issue_qj_busy && lsb_cdb_valid && lsb_cdb_name == issue_qj) begin
      issue_j_bypass = 1'b1;
      issue_j_value  = lsb_cdb_value;
    end
    issue_k_bypass = 1'b0;
    issue_k_value  = issue_vk;
    if (issue_qk_busy && alu_cdb_valid && alu_cdb_name == issue_qk) begin
      issue_k_bypass = 1'b1;
      issue_k_value  = alu_cdb_value;
    end else if (issue_qk_busy && lsb_cdb_valid && lsb_cdb_name == issue_qk) begin
      issue_k_bypass = 1'b1;
      issue_k_value  = lsb_cdb_value;
    end
  end

  // Next state: wakeup, dispatch, issue; flush drops everything
  always_comb begin
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    opcode_d  = opcode_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    name_d    = name_q;
`ifdef RS_AGE_SELECT_EN
    seq_d     = seq_q;
    seq_cnt_d = seq_cnt_q;
`endif
    alu_en_d     = 1'b0;
    alu_pc_d     = alu_pc_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    alu_imm_d    = alu_imm_q;
    alu_opcode_d = alu_opcode_q;
    alu_name_d   = alu_name_q;

    if (flush) begin
      busy_d = '0;
`ifdef RS_AGE_SELECT_EN
      seq_cnt_d = '0;
`endif
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_name == qj_q[i]) begin
            vj_d[i] = alu_cdb_value;
            qj_busy_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_name == qj_q[i]) begin
            vj_d[i] = lsb_cdb_value;
            qj_busy_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (alu_cdb_valid && alu_cdb_name == qk_q[i]) begin
            vk_d[i] = alu_cdb_value;
            qk_busy_d[i] = 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_name == qk_q[i]) begin
            vk_d[i] = lsb_cdb_value;
            qk_busy_d[i] = 1'b0;
          end
        end
      end

      if (sel_found) begin
        alu_en_d        = 1'b1;
        alu_pc_d        = pc_q[sel_idx];
        alu_rs1_d       = vj_q[sel_idx];
        alu_rs2_d       = vk_q[sel_idx];
        alu_imm_d       = imm_q[sel_idx];
        alu_opcode_d    = opcode_q[sel_idx];
        alu_name_d      = name_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end

      // The selected slot was busy, so it can never be the free slot
      if (issue_valid && !rs_full) begin
        busy_d[free_idx]    = 1'b1;
        opcode_d[free_idx]  = issue_opcode;
        pc_d[free_idx]      = issue_pc;
        imm_d[free_idx]     = issue_imm;
        name_d[free_idx]    = issue_name;
        qj_d[free_idx]      = issue_qj;
        qk_d[free_idx]      = issue_qk;
        vj_d[free_idx]      = issue_j_value;
        vk_d[free_idx]      = issue_k_value;
        qj_busy_d[free_idx] = issue_qj_busy && !issue_j_bypass;
        qk_busy_d[free_idx] = issue_qk_busy && !issue_k_bypass;
`ifdef RS_AGE_SELECT_EN
        seq_d[free_idx]     = seq_cnt_q;
        seq_cnt_d           = seq_cnt_q + 1'b1;
`endif
      end
    end
  end

  // State register: reset clears, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      qj_busy_q    <= '0;
      qk_busy_q    <= '0;
      alu_en_q     <= 1'b0;
      alu_pc_q     <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      alu_imm_q    <= '0;
      alu_opcode_q <= '0;
      alu_name_q   <= '0;
`ifdef RS_AGE_SELECT_EN
      seq_cnt_q    <= '0;
`endif
    end else if (rdy) begin
      busy_q       <= busy_d;
      qj_busy_q    <= qj_busy_d;
      qk_busy_q    <= qk_busy_d;
      opcode_q     <= opcode_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      name_q       <= name_d;
`ifdef RS_AGE_SELECT_EN
      seq_q        <= seq_d;
      seq_cnt_q    <= seq_cnt_d;
`endif
      alu_en_q     <= alu_en_d;
      alu_pc_q     <= alu_pc_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      alu_imm_q    <= alu_imm_d;
      alu_opcode_q <= alu_opcode_d;
      alu_name_q   <= alu_name_d;
    end
  end

  assign alu_en     = alu_en_q;
  assign alu_pc     = alu_pc_q;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;
  assign alu_imm    = alu_imm_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_name   = alu_name_q;

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// slot-list behavioural model. Honours RS_AGE_SELECT_EN if defined.
module tb_reservation_station;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, issue_valid;
  logic [6:0]  issue_opcode;
  logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
  logic [4:0]  issue_qj, issue_qk, issue_name;
  logic        issue_qj_busy, issue_qk_busy;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [4:0]  alu_cdb_name, lsb_cdb_name;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        rs_full, alu_en;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [6:0]  alu_opcode;
  logic [4:0]  alu_name;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_qj_busy(issue_qj_busy),
    .issue_qk_busy(issue_qk_busy), .issue_name(issue_name),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_name(alu_cdb_name), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_name(lsb_cdb_name), .lsb_cdb_value(lsb_cdb_value),
    .rs_full(rs_full), .alu_en(alu_en), .alu_pc(alu_pc), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_opcode(alu_opcode), .alu_name(alu_name)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A slot holds an op; an operand is "have" once its value is known.
  bit          m_valid [N];
  bit          m_hj [N], m_hk [N];
  logic [31:0] m_vj [N], m_vk [N], m_pc [N], m_imm [N];
  logic [4:0]  m_tj [N], m_tk [N], m_name [N];
  logic [6:0]  m_op [N];
  int          m_age [N];
  int          m_age_cnt;
  bit          o_en;
  logic [31:0] o_pc, o_rs1, o_rs2, o_imm;
  logic [6:0]  o_op;
  logic [4:0]  o_name;
  bit          started = 0;

  function automatic bit cdb_hit(input logic [4:0] tag, output logic [31:0] val);
    val = '0;
    if (alu_cdb_valid && alu_cdb_name == tag) begin val = alu_cdb_value; return 1; end
    if (lsb_cdb_valid && lsb_cdb_name == tag) begin val = lsb_cdb_value; return 1; end
    return 0;
  endfunction

  always @(posedge clk) begin
    int sel, fr;
    bit full;
    logic [31:0] v;
    started = 1;
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      o_en = 0; o_pc = 0; o_rs1 = 0; o_rs2 = 0; o_imm = 0; o_op = 0; o_name = 0;
      m_age_cnt = 0;
    end else if (!rdy) begin
      // frozen
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      o_en = 0;
      m_age_cnt = 0;
    end else begin
      full = 1;
      for (int i = 0; i < N; i++) if (!m_valid[i]) full = 0;
      sel = -1;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && m_hj[i] && m_hk[i]) begin
`ifdef RS_AGE_SELECT_EN
          if (sel < 0 || m_age[i] < m_age[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && !m_hj[i] && cdb_hit(m_tj[i], v)) begin m_vj[i] = v; m_hj[i] = 1; end
        if (m_valid[i] && !m_hk[i] && cdb_hit(m_tk[i], v)) begin m_vk[i] = v; m_hk[i] = 1; end
      end
      if (sel >= 0) begin
        o_en = 1; o_pc = m_pc[sel]; o_rs1 = m_vj[sel]; o_rs2 = m_vk[sel];
        o_imm = m_imm[sel]; o_op = m_op[sel]; o_name = m_name[sel];
        m_valid[sel] = 0;
      end else begin
        o_en = 0;
      end
      if (issue_valid && !full) begin
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i] && i != sel) fr = i;
        m_valid[fr] = 1; m_op[fr] = issue_opcode; m_pc[fr] = issue_pc;
        m_imm[fr] = issue_imm; m_name[fr] = issue_name;
        m_tj[fr] = issue_qj; m_tk[fr] = issue_qk;
        m_hj[fr] = !issue_qj_busy; m_vj[fr] = issue_vj;
        m_hk[fr] = !issue_qk_busy; m_vk[fr] = issue_vk;
        if (issue_qj_busy && cdb_hit(issue_qj, v)) begin m_hj[fr] = 1; m_vj[fr] = v; end
        if (issue_qk_busy && cdb_hit(issue_qk, v)) begin m_hk[fr] = 1; m_vk[fr] = v; end
        m_age[fr] = m_age_cnt;
        m_age_cnt++;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    bit full;
    if (started) begin
      full = 1;
      for (int i = 0; i < N; i++) if (!m_valid[i]) full = 0;
      chk("rs_full", {31'd0, rs_full}, {31'd0, full});
      chk("alu_en", {31'd0, alu_en}, {31'd0, o_en});
      chk("alu_pc", alu_pc, o_pc);
      chk("alu_rs1", alu_rs1, o_rs1);
      chk("alu_rs2", alu_rs2, o_rs2);
      chk("alu_imm", alu_imm, o_imm);
      chk("alu_opcode", {25'd0, alu_opcode}, {25'd0, o_op});
      chk("alu_name", {27'd0, alu_name}, {27'd0, o_name});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0; issue_valid = 0;
    alu_cdb_valid = 0; lsb_cdb_valid = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic issue_op(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjb, input logic [4:0] qj,
                          input logic qkb, input logic [4:0] qk, input logic [4:0] nm);
    issue_valid = 1; issue_opcode = op; issue_pc = pc; issue_imm = imm;
    issue_vj = vj; issue_vk = vk; issue_qj_busy = qjb; issue_qj = qj;
    issue_qk_busy = qkb; issue_qk = qk; issue_name = nm;
  endtask

  task automatic cdb_alu(input logic [4:0] nm, input logic [31:0] val);
    alu_cdb_valid = 1; alu_cdb_name = nm; alu_cdb_value = val;
  endtask

  task automatic cdb_lsb(input logic [4:0] nm, input logic [31:0] val);
    lsb_cdb_valid = 1; lsb_cdb_name = nm; lsb_cdb_value = val;
  endtask

  initial begin
    idle();
    rst = 1;
    issue_opcode = 0; issue_pc = 0; issue_imm = 0; issue_vj = 0; issue_vk = 0;
    issue_qj = 0; issue_qk = 0; issue_qj_busy = 0; issue_qk_busy = 0; issue_name = 0;
    alu_cdb_name = 0; alu_cdb_value = 0; lsb_cdb_name = 0; lsb_cdb_value = 0;
    tick(); tick();
    rst = 0;
    chk("reset_en", {31'd0, alu_en}, 32'd0);
    chk("reset_full", {31'd0, rs_full}, 32'd0);
    chk("reset_pc", alu_pc, 32'd0);
    chk("reset_name", {27'd0, alu_name}, 32'd0);

    // 1: ready ADDI dispatches one edge after issue
    issue_op(7'd1, 32'h100, 32'd3, 32'd5, 32'd0, 0, 5'd0, 0, 5'd0, 5'd2);
    tick(); idle();
    chk("t1_en_early", {31'd0, alu_en}, 32'd0);
    tick();
    chk("t1_en", {31'd0, alu_en}, 32'd1);
    chk("t1_rs1", alu_rs1, 32'd5);
    chk("t1_imm", alu_imm, 32'd3);
    chk("t1_name", {27'd0, alu_name}, 32'd2);

    // 2: wait on tag 7, woken by ALU CDB
    issue_op(7'd2, 32'h200, 32'd0, 32'd0, 32'd1, 1, 5'd7, 0, 5'd0, 5'd4);
    tick(); idle(); tick(); tick();
    cdb_alu(5'd7, 32'd40);
    tick(); idle();
    chk("t2_en_early", {31'd0, alu_en}, 32'd0);
    tick();
    chk("t2_en", {31'd0, alu_en}, 32'd1);
    chk("t2_rs1", alu_rs1, 32'd40);
    chk("t2_rs2", alu_rs2, 32'd1);

    // 3: issue-time bypass from LSB CDB
    issue_op(7'd3, 32'h300, 32'd0, 32'h11, 32'd0, 0, 5'd0, 1, 5'd9, 5'd6);
    cdb_lsb(5'd9, 32'hDEAD);
    tick(); idle(); tick();
    chk("t3_en", {31'd0, alu_en}, 32'd1);
    chk("t3_rs1", alu_rs1, 32'h11);
    chk("t3_rs2", alu_rs2, 32'hDEAD);

    // 4: fill all 16 slots, 17th ignored, then drain in index order
    for (int k = 0; k < N; k++) begin
      issue_op(7'd4, 32'(k * 4), 32'(k), 32'(k), 32'd0, 1, 5'd3, 0, 5'd0, 5'(k));
      tick();
    end
    chk("t4_full", {31'd0, rs_full}, 32'd1);
    issue_op(7'd4, 32'h444, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 5'd0, 5'd20);
    tick(); idle();
    chk("t4_full17", {31'd0, rs_full}, 32'd1);
    cdb_alu(5'd3, 32'd100);
    tick(); idle();
    chk("t4_no17", {31'd0, alu_en}, 32'd0);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t4_drain_en", {31'd0, alu_en}, 32'd1);
      chk("t4_drain_name", {27'd0, alu_name}, 32'(k));
      chk("t4_drain_rs1", alu_rs1, 32'd100);
    end
    tick();
    chk("t4_done_en", {31'd0, alu_en}, 32'd0);
    chk("t4_done_full", {31'd0, rs_full}, 32'd0);

    // 5: flush drops waiting entries and the op issued in the flush cycle
    for (int k = 0; k < 4; k++) begin
      issue_op(7'd5, 32'h500, 32'd0, 32'd0, 32'd0, 1, 5'(10 + k), 0, 5'd0, 5'(8 + k));
      tick();
    end
    idle();
    issue_op(7'd5, 32'h5ff, 32'd0, 32'd1, 32'd2, 0, 5'd0, 0, 5'd0, 5'd30);
    flush = 1;
    tick(); idle();
    chk("t5_flush_en", {31'd0, alu_en}, 32'd0);
    chk("t5_flush_full", {31'd0, rs_full}, 32'd0);
    cdb_alu(5'd10, 32'd1); cdb_lsb(5'd11, 32'd2);
    tick(); idle();
    cdb_alu(5'd12, 32'd3); cdb_lsb(5'd13, 32'd4);
    tick(); idle();
    chk("t5_none1", {31'd0, alu_en}, 32'd0);
    tick();
    chk("t5_none2", {31'd0, alu_en}, 32'd0);

    // 6: slot reuse vs. age ordering
    do_reset();
    issue_op(7'd6, 32'h600, 32'd0, 32'd0, 32'd0, 1, 5'd4, 0, 5'd0, 5'd1);
    tick();
    issue_op(7'd6, 32'h604, 32'd0, 32'd0, 32'd0, 1, 5'd5, 0, 5'd0, 5'd2);
    tick(); idle();
    cdb_alu(5'd4, 32'd44);
    tick(); idle();
    tick();
    chk("t6_a_en", {31'd0, alu_en}, 32'd1);
    chk("t6_a_name", {27'd0, alu_name}, 32'd1);
    chk("t6_a_rs1", alu_rs1, 32'd44);
    issue_op(7'd6, 32'h608, 32'd0, 32'd7, 32'd0, 0, 5'd0, 0, 5'd0, 5'd3);
    cdb_alu(5'd5, 32'd55);
    tick(); idle();
    chk("t6_gap", {31'd0, alu_en}, 32'd0);
    tick();
`ifdef RS_AGE_SELECT_EN
    chk("t6_first", {27'd0, alu_name}, 32'd2);
`else
    chk("t6_first", {27'd0, alu_name}, 32'd3);
`endif
    tick();
`ifdef RS_AGE_SELECT_EN
    chk("t6_second", {27'd0, alu_name}, 32'd3);
`else
    chk("t6_second", {27'd0, alu_name}, 32'd2);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 79) == 0);
      issue_valid   = $urandom_range(0, 1) == 1;
      issue_opcode  = 7'($urandom);
      issue_pc      = $urandom;
      issue_imm     = $urandom;
      issue_vj      = $urandom;
      issue_vk      = $urandom;
      issue_qj_busy = ($urandom_range(0, 2) != 0);
      issue_qk_busy = ($urandom_range(0, 2) == 0);
      issue_qj      = 5'($urandom_range(0, 7));
      issue_qk      = 5'($urandom_range(0, 7));
      issue_name    = 5'($urandom);
      alu_cdb_valid = $urandom_range(0, 1) == 1;
      lsb_cdb_valid = $urandom_range(0, 2) == 0;
      alu_cdb_name  = 5'($urandom_range(0, 7));
      lsb_cdb_name  = 5'((32'(alu_cdb_name) + 1 + $urandom_range(0, 6)) % 8);
      alu_cdb_value = $urandom;
      lsb_cdb_value = $urandom;
      tick();
    end
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
